// File: rtl/magnitude_comparator_2bit.sv
// Registered magnitude comparator: one-hot eq/gt/lt flags one cycle after in_valid.
// SIGNED_CMP selects two's-complement instead of unsigned ordering.
module magnitude_comparator_2bit #(
  parameter int WIDTH      = 2,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    SIGNED_CMP ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  logic             eq_d, gt_d, lt_d;
  logic             eq_q, gt_q, lt_q;
  logic             valid_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eq_d  = 1'b0;
    gt_d  = 1'b0;
    lt_d  = 1'b0;
    a_cmp = a ^ SIGN_MASK;
    b_cmp = b ^ SIGN_MASK;
    if (a_cmp == b_cmp)     eq_d = 1'b1;
    else if (a_cmp > b_cmp) gt_d = 1'b1;
    else                    lt_d = 1'b1;
  end

  // Flags hold their last result while in_valid is low; only out_valid drops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      valid_q <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        eq_q <= eq_d;
        gt_q <= gt_d;
        lt_q <= lt_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_magnitude_comparator_2bit.sv
// Bench for magnitude_comparator_2bit: unsigned and signed 2-bit instances driven
// in parallel from a directed vector table plus reset/hold sequences.
module tb_magnitude_comparator_2bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] a, b;
  logic       out_valid_u, eq_u, gt_u, lt_u;
  logic       out_valid_s, eq_s, gt_s, lt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  magnitude_comparator_2bit #(.WIDTH(2), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid_u), .eq(eq_u), .gt(gt_u), .lt(lt_u)
  );

  magnitude_comparator_2bit #(.WIDTH(2), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid_s), .eq(eq_s), .gt(gt_s), .lt(lt_s)
  );

  // Flag encoding {eq, gt, lt}
  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] exp_u;
    logic [2:0] exp_s;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic v, input logic [1:0] ai, input logic [1:0] bi);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = ai;
    b        = bi;
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string name, input logic vld,
                            input logic [2:0] exp_u, input logic [2:0] exp_s);
    check({name, "_u"}, {out_valid_u, eq_u, gt_u, lt_u}, {vld, exp_u});
    check({name, "_s"}, {out_valid_s, eq_s, gt_s, lt_s}, {vld, exp_s});
  endtask

  initial begin
    vecs[0] = '{2'b00, 2'b00, EQ, EQ};
    vecs[1] = '{2'b01, 2'b00, GT, GT};
    vecs[2] = '{2'b10, 2'b01, GT, LT};
    vecs[3] = '{2'b11, 2'b10, GT, GT};
    vecs[4] = '{2'b10, 2'b11, LT, LT};
    vecs[5] = '{2'b00, 2'b01, LT, LT};
    vecs[6] = '{2'b11, 2'b11, EQ, EQ};
    vecs[7] = '{2'b11, 2'b01, GT, LT};

    rst = 1'b1; in_valid = 1'b1; a = 2'b01; b = 2'b00;

    // Reset held two cycles with in_valid asserted
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 2'b01, 2'b00);
      check_both("reset", 1'b0, NONE, NONE);
    end

    // Directed table, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, vecs[i].a, vecs[i].b);
      check_both($sformatf("vec%0d", i), 1'b1, vecs[i].exp_u, vecs[i].exp_s);
    end

    // Exhaustive 16 pairs against a behavioural model, plus one-hot check
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        logic [1:0] av, bv;
        logic [2:0] eu, es;
        av = 2'(ia);
        bv = 2'(ib);
        eu = {av == bv, av > bv, av < bv};
        es = {$signed(av) == $signed(bv), $signed(av) > $signed(bv), $signed(av) < $signed(bv)};
        step(1'b0, 1'b1, av, bv);
        check_both($sformatf("exh_%0d_%0d", ia, ib), 1'b1, eu, es);
        check("onehot_u", 4'($countones({eq_u, gt_u, lt_u})), 4'd1);
      end
    end

    // Hold: flags stay while in_valid is low, even with changed operands
    step(1'b0, 1'b1, 2'b11, 2'b01);
    check_both("hold_load", 1'b1, GT, LT);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b00, 2'b11);
      check_both($sformatf("hold%0d", i), 1'b0, GT, LT);
    end

    // Reset mid-stream discards the capture on the same edge
    step(1'b0, 1'b1, 2'b00, 2'b00);
    check_both("pre_rst", 1'b1, EQ, EQ);
    step(1'b1, 1'b1, 2'b01, 2'b10);
    check_both("mid_rst", 1'b0, NONE, NONE);
    step(1'b0, 1'b1, 2'b01, 2'b10);
    check_both("post_rst", 1'b1, LT, GT);
    step(1'b0, 1'b0, 2'b00, 2'b00);
    check_both("post_rst_idle", 1'b0, LT, GT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
